// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - condition codes, flag indices and condition evaluation
package alu_pkg;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [3:0] {
      EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
      MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
      HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
      GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
   } cond_t;

   // NV has no meaning of its own here and executes like AL
   function automatic logic cond_check(input cond_t cond, input logic [3:0] flags);
      logic n, z, c, v;
      n = flags[FLAG_N];
      z = flags[FLAG_Z];
      c = flags[FLAG_C];
      v = flags[FLAG_V];
      case (cond)
         EQ:      return z;
         NE:      return !z;
         CS:      return c;
         CC:      return !c;
         MI:      return n;
         PL:      return !n;
         VS:      return v;
         VC:      return !v;
         HI:      return c && !z;
         LS:      return !c || z;
         GE:      return n == v;
         LT:      return n != v;
         GT:      return !z && (n == v);
         LE:      return z || (n != v);
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/alu_writeback_stage_if.sv
// rtl/alu_writeback_stage_if.sv - upstream and downstream handshake bundle of the write-back stage
interface alu_wb_if #(
   parameter int WIDTH = 32,
   parameter int RADDR = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_result;
   logic [3:0]       in_flags;
   logic [RADDR-1:0] in_rd;
   logic [3:0]       in_cond;
   logic [1:0]       in_flag_write;
   logic             in_reg_write;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic [RADDR-1:0] out_rd;
   logic             out_reg_write;

   modport slave (
      input  in_valid, in_result, in_flags, in_rd, in_cond, in_flag_write, in_reg_write, out_ready,
      output in_ready, out_valid, out_result, out_rd, out_reg_write
   );

   modport master (
      output in_valid, in_result, in_flags, in_rd, in_cond, in_flag_write, in_reg_write, out_ready,
      input  in_ready, out_valid, out_result, out_rd, out_reg_write
   );
endinterface

// File: rtl/wb_fifo2.sv
// rtl/wb_fifo2.sv - generic 2-entry in-order valid/ready queue
module wb_fifo2 #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);
   logic [DATA_W-1:0] mem_q [2];
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        count_q, count_d;
   logic              push, pop;

   // ready comes from occupancy alone, so no combinational path from out_ready
   assign in_ready  = rst_n && (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end

endmodule

// File: rtl/alu_writeback_stage.sv
// rtl/alu_writeback_stage.sv - NZCV flag register, condition evaluation and gated write-back queue
module alu_writeback_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int RADDR = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   alu_wb_if.slave     wb,
   output logic        cond_ex,
   output logic [3:0]  flags_q
);
   localparam int PW = WIDTH + RADDR + 1;

   logic [3:0]    flags_d;
   logic          accept;
   logic [PW-1:0] enq_data;
   logic [PW-1:0] deq_data;

   assign cond_ex  = cond_check(cond_t'(wb.in_cond), flags_q);
   assign accept   = wb.in_valid && wb.in_ready;
   // failed instructions still occupy a slot so downstream order and count are kept
   assign enq_data = {wb.in_result, wb.in_rd, wb.in_reg_write && cond_ex};

   always_comb begin
      flags_d = flags_q;
      if (accept && cond_ex) begin
         if (wb.in_flag_write[1]) begin
            flags_d[FLAG_N] = wb.in_flags[FLAG_N];
            flags_d[FLAG_Z] = wb.in_flags[FLAG_Z];
         end
         if (wb.in_flag_write[0]) begin
            flags_d[FLAG_C] = wb.in_flags[FLAG_C];
            flags_d[FLAG_V] = wb.in_flags[FLAG_V];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) flags_q <= 4'b0000;
      else          flags_q <= flags_d;
   end

   wb_fifo2 #(.DATA_W(PW)) u_fifo (
      .clk       (clk),
      .rst_n     (reset_n),
      .in_valid  (wb.in_valid),
      .in_ready  (wb.in_ready),
      .in_data   (enq_data),
      .out_valid (wb.out_valid),
      .out_ready (wb.out_ready),
      .out_data  (deq_data)
   );

   assign {wb.out_result, wb.out_rd, wb.out_reg_write} = deq_data;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// tb/tb_alu_writeback_stage.sv - directed bench with a queue-level reference model
module tb_alu_writeback_stage;
   logic       clk = 1'b0;
   logic       reset_n;
   logic       cond_ex;
   logic [3:0] flags_q;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   alu_wb_if #(.WIDTH(32), .RADDR(4)) wb ();

   alu_writeback_stage #(.WIDTH(32), .RADDR(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .wb      (wb),
      .cond_ex (cond_ex),
      .flags_q (flags_q)
   );

   typedef struct packed {
      logic [31:0] res;
      logic [3:0]  rd;
      logic        rw;
   } ent_t;

   ent_t       m_q[$];
   logic [3:0] m_flags = 4'b0000;

   function automatic logic passes(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cy;
         4'd3:  return !cy;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cy & !z;
         4'd9:  return !cy | z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z & (n == v);
         4'd13: return z | (n != v);
         default: return 1'b1;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // model advances on the rising edge, outputs are compared on the falling edge
   always begin
      @(posedge clk);
      if (!reset_n) begin
         m_q.delete();
         m_flags = 4'b0000;
      end else begin
         logic ce, push, pop;
         ent_t e;
         ce   = passes(wb.in_cond, m_flags);
         push = wb.in_valid && (m_q.size() < 2);
         pop  = (m_q.size() > 0) && wb.out_ready;
         if (pop) void'(m_q.pop_front());
         if (push) begin
            if (ce && wb.in_flag_write[1]) m_flags[3:2] = wb.in_flags[3:2];
            if (ce && wb.in_flag_write[0]) m_flags[1:0] = wb.in_flags[1:0];
            e.res = wb.in_result;
            e.rd  = wb.in_rd;
            e.rw  = wb.in_reg_write & ce;
            m_q.push_back(e);
         end
      end
      @(negedge clk);
      if (!reset_n) begin
         m_q.delete();
         m_flags = 4'b0000;
      end
      chk("in_ready", {31'd0, wb.in_ready}, {31'd0, reset_n && (m_q.size() < 2)});
      chk("out_valid", {31'd0, wb.out_valid}, {31'd0, m_q.size() > 0});
      chk("flags_q", {28'd0, flags_q}, {28'd0, m_flags});
      chk("cond_ex", {31'd0, cond_ex}, {31'd0, passes(wb.in_cond, m_flags)});
      if (m_q.size() > 0) begin
         chk("out_result", wb.out_result, m_q[0].res);
         chk("out_rd", {28'd0, wb.out_rd}, {28'd0, m_q[0].rd});
         chk("out_reg_write", {31'd0, wb.out_reg_write}, {31'd0, m_q[0].rw});
      end else begin
         chk("out_result_empty", wb.out_result, 32'd0);
         chk("out_rd_empty", {28'd0, wb.out_rd}, 32'd0);
         chk("out_reg_write_empty", {31'd0, wb.out_reg_write}, 32'd0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] res, input logic [3:0] fl,
                        input logic [3:0] rd, input logic [3:0] cond,
                        input logic [1:0] fw, input logic rw);
      wb.in_valid      = v;
      wb.in_result     = res;
      wb.in_flags      = fl;
      wb.in_rd         = rd;
      wb.in_cond       = cond;
      wb.in_flag_write = fw;
      wb.in_reg_write  = rw;
   endtask

   initial begin
      logic [3:0] sweep [6];
      sweep = '{4'b0000, 4'b1111, 4'b0101, 4'b1010, 4'b0110, 4'b1001};
      reset_n = 1'b0;
      wb.out_ready = 1'b1;
      drive(1'b0, 32'd0, 4'd0, 4'd0, 4'hE, 2'b00, 1'b0);
      step(); step();
      chk("lit_ready_in_reset", {31'd0, wb.in_ready}, 32'd0);
      reset_n = 1'b1;
      step();
      chk("lit_ready_after_release", {31'd0, wb.in_ready}, 32'd1);

      // flag write then EQ passes
      drive(1'b1, 32'd0, 4'b0110, 4'd1, 4'hE, 2'b11, 1'b0);
      step();
      chk("lit_flags_0110", {28'd0, flags_q}, 32'h6);
      drive(1'b1, 32'h5, 4'b0000, 4'd2, 4'h0, 2'b00, 1'b1);
      #1 chk("lit_eq_cond_ex", {31'd0, cond_ex}, 32'd1);
      step();
      chk("lit_eq_result", wb.out_result, 32'h5);
      chk("lit_eq_reg_write", {31'd0, wb.out_reg_write}, 32'd1);

      // condition fail keeps flags, enqueues with write disabled
      drive(1'b1, 32'h7, 4'b1001, 4'd3, 4'h1, 2'b11, 1'b1);
      #1 chk("lit_ne_cond_ex", {31'd0, cond_ex}, 32'd0);
      step();
      chk("lit_ne_result", wb.out_result, 32'h7);
      chk("lit_ne_reg_write", {31'd0, wb.out_reg_write}, 32'd0);
      chk("lit_ne_flags", {28'd0, flags_q}, 32'h6);

      // partial update of N,Z only
      drive(1'b1, 32'h0, 4'b0000, 4'd0, 4'hE, 2'b11, 1'b0);
      step();
      drive(1'b1, 32'h0, 4'b1111, 4'd0, 4'hE, 2'b10, 1'b0);
      step();
      chk("lit_partial_flags", {28'd0, flags_q}, 32'hC);
      drive(1'b0, 32'h0, 4'b0000, 4'd0, 4'hB, 2'b00, 1'b0);
      #1 chk("lit_lt", {31'd0, cond_ex}, 32'd1);
      wb.in_cond = 4'hA;
      #1 chk("lit_ge", {31'd0, cond_ex}, 32'd0);

      // every condition code against a spread of flag values
      for (int s = 0; s < 6; s++) begin
         drive(1'b1, 32'h0, sweep[s], 4'd0, 4'hE, 2'b11, 1'b0);
         step();
         wb.in_valid = 1'b0;
         for (int c = 0; c < 16; c++) begin
            wb.in_cond = 4'(c);
            step();
         end
      end

      // backpressure with a full queue
      drive(1'b0, 32'h0, 4'b0000, 4'd0, 4'hE, 2'b00, 1'b0);
      step(); step();
      wb.out_ready = 1'b0;
      drive(1'b1, 32'hA, 4'b0000, 4'd4, 4'hE, 2'b00, 1'b1);
      step();
      drive(1'b1, 32'hB, 4'b0000, 4'd5, 4'hE, 2'b00, 1'b1);
      step();
      chk("lit_full_not_ready", {31'd0, wb.in_ready}, 32'd0);
      drive(1'b1, 32'hC, 4'b1111, 4'd6, 4'hE, 2'b11, 1'b1);
      step();
      chk("lit_full_flags_held", {28'd0, flags_q}, 32'h9);
      wb.in_valid  = 1'b0;
      wb.out_ready = 1'b1;
      #1 chk("lit_bp_first", wb.out_result, 32'hA);
      step();
      chk("lit_bp_second", wb.out_result, 32'hB);
      chk("lit_bp_ready", {31'd0, wb.in_ready}, 32'd1);
      step();
      chk("lit_bp_empty", {31'd0, wb.out_valid}, 32'd0);

      // simultaneous push/pop and bubble-free streaming
      drive(1'b1, 32'h1, 4'b0000, 4'd1, 4'hE, 2'b00, 1'b1);
      step();
      drive(1'b1, 32'h2, 4'b0000, 4'd2, 4'hE, 2'b00, 1'b1);
      step();
      chk("lit_simul_head", wb.out_result, 32'h2);
      for (int i = 0; i < 8; i++) begin
         wb.in_result = 32'(16 + i);
         step();
         chk("lit_stream", wb.out_result, 32'(16 + i));
      end
      wb.in_valid = 1'b0;
      step();

      // reset while two entries are queued
      wb.out_ready = 1'b0;
      drive(1'b1, 32'h33, 4'b1111, 4'd7, 4'hE, 2'b11, 1'b1);
      step();
      drive(1'b1, 32'h44, 4'b0000, 4'd8, 4'hE, 2'b00, 1'b1);
      step();
      wb.in_valid = 1'b0;
      chk("lit_two_queued", {31'd0, wb.out_valid}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("lit_rst_valid", {31'd0, wb.out_valid}, 32'd0);
      chk("lit_rst_flags", {28'd0, flags_q}, 32'd0);
      chk("lit_rst_ready", {31'd0, wb.in_ready}, 32'd0);
      chk("lit_rst_result", wb.out_result, 32'd0);
      step(); step();
      reset_n = 1'b1;
      step();
      chk("lit_post_rst_ready", {31'd0, wb.in_ready}, 32'd1);
      chk("lit_post_rst_valid", {31'd0, wb.out_valid}, 32'd0);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
